subleq_loader: RTL and testbench
================================

# subleq_loader

Boot-time program loader for the subleq system. It accepts a byte stream on a valid/ready interface and assembles big-endian 16-bit words. It writes those words into the unified word memory starting at address 0 and holds the CPU in reset until the image is complete. It is the write-side counterpart to the memory dump used during simulation: it fills memory, and the dump reads it back.

## Interface
- WORD_SIZE, 16, memory word width in bits; must be 16. The byte protocol is fixed at two bytes per word.
- ADDR_WIDTH, 16, memory address width.
- MEM_WORDS, 256, number of loadable words; a header count above this is an error.

- clk  in  1  system clock; all logic on rising edge.
- areset  in  1  reset, synchronous, active-high.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  memory write enable, one cycle per word.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  WORD_SIZE  write data.
- cpu_hold  out  1  held high to keep the CPU in reset until loading finishes.
- done  out  1  image fully written.
- err  out  1  header count exceeded MEM_WORDS.

## Operation
- Stream format:
  - Header: count N, 2 bytes, high byte first.
  - Body: N words, 2 bytes each, high byte first.
  - Words go to addresses 0 .. N-1.
- A byte is accepted on a rising edge with in_valid && in_ready. Bytes are never accepted while in_ready is low.
- States:
  - CNT_HI: accept a byte into count[15:8]; go to CNT_LO.
  - CNT_LO: accept a byte into count[7:0]. Then:
    - if the full count is 0, go to DONE;
    - if it is greater than MEM_WORDS, go to ERR;
    - otherwise clear addr to 0 and go to DATA_HI.
  - DATA_HI: accept a byte into word[15:8]; go to DATA_LO.
  - DATA_LO: accept a byte into word[7:0]; go to WRITE.
  - WRITE: drive mem_we=1, mem_addr=addr, mem_wdata=word for exactly this cycle. Then:
    - if addr == N-1, go to DONE;
    - otherwise addr <= addr+1 and go to DATA_HI.
  - DONE: terminal. done=1, cpu_hold=0, in_ready=0.
  - ERR: terminal. err=1, cpu_hold=1, in_ready=0; no memory writes.
- in_ready=1 exactly in CNT_HI, CNT_LO, DATA_HI and DATA_LO.
- Outputs are decoded from the state register. No combinational path exists from in_valid to any output.
- addr is ADDR_WIDTH bits wide. N ≤ MEM_WORDS guarantees it never wraps. The comparison uses the full 16-bit count, never a truncated one.
- After DONE or ERR, further stream bytes are ignored. The only way to reload is areset.

## Timing
- Reset values, taking effect on the edge where areset=1:
  - state=CNT_HI;
  - in_ready=1 (from the next cycle onward);
  - mem_we=0, mem_addr=0, mem_wdata=0;
  - cpu_hold=1, done=0, err=0;
  - count=0, addr=0.
- Reset mid-load:
  - takes priority over any handshake in that cycle;
  - the byte presented that cycle is dropped;
  - already-written memory words are left as they are;
  - cpu_hold stays 1.
- Minimum cost per word is 3 cycles: DATA_HI, DATA_LO, WRITE. With in_valid held high, a load of N words takes 2 + 3N cycles from the first accepted byte to entry into DONE.
- Stalls:
  - With in_valid low in an accepting state, the loader holds state and registers.
  - There is no timeout.
- mem_we pulses are one cycle wide, and consecutive writes are at least 3 cycles apart.
- Write-to-done ordering:
  - done and cpu_hold=0 appear the cycle after the final mem_we pulse.
  - The CPU therefore never runs while a write is pending.
- err asserts the cycle after the CNT_LO byte is accepted, with no intervening mem_we.

## Test plan
- Reset, then stream 00 03 | 12 34 | AB CD | 00 00 with in_valid held high:
  - mem_we pulses at addr 0,1,2 with data 1234, ABCD, 0000;
  - done=1 and cpu_hold=0 exactly 11 cycles after the first byte is accepted.
- Header 00 00:
  - no mem_we;
  - done=1 the cycle after the second byte;
  - in_ready=0 thereafter.
- Header 01 01 with MEM_WORDS=256:
  - err=1, cpu_hold=1, in_ready=0;
  - no writes; following bytes are not consumed.
- Same stream as the first scenario, with in_valid deasserted for 5 cycles between every byte:
  - identical writes and final state; only the timing stretches;
  - no byte is lost or duplicated.
- Assert areset for one cycle while in DATA_LO of word 1:
  - word 0 remains written;
  - state returns to CNT_HI, cpu_hold=1, done=0;
  - a fresh 00 01 | BE EF stream then writes BEEF at addr 0 and reaches DONE.

Source files
------------

// File: rtl/subleq_loader.sv
// Boot loader: assembles a big-endian byte stream (count header, then words)
// into memory writes from address 0, holding the CPU in reset until complete.
module subleq_loader #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t                  state, state_nxt;
    logic [15:0]             count;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [WORD_SIZE-1:0]    word;
    logic                    accept;
    logic [15:0]             count_full;
    logic                    last_word;

    assign accept     = in_valid && in_ready;
    assign count_full = {count[15:8], in_data};
    // Compare at 32 bits so neither the count nor addr is ever truncated.
    assign last_word  = (32'(addr) == (32'(count) - 32'd1));

    always_ff @(posedge clk) begin
        if (areset) begin
            state <= CNT_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CNT_HI:  if (accept) state_nxt = CNT_LO;
            CNT_LO: begin
                if (accept) begin
                    if (count_full == 16'd0)
                        state_nxt = DONE;
                    else if (32'(count_full) > 32'(MEM_WORDS))
                        state_nxt = ERR;
                    else
                        state_nxt = DATA_HI;
                end
            end
            DATA_HI: if (accept) state_nxt = DATA_LO;
            DATA_LO: if (accept) state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? DONE : DATA_HI;
            DONE:    state_nxt = DONE;
            ERR:     state_nxt = ERR;
            default: state_nxt = CNT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            count <= '0;
            addr  <= '0;
            word  <= '0;
        end else begin
            if (accept) begin
                case (state)
                    CNT_HI:  count[15:8] <= in_data;
                    CNT_LO: begin
                        count[7:0] <= in_data;
                        addr       <= '0;
                    end
                    DATA_HI: word[15:8] <= in_data;
                    DATA_LO: word[7:0]  <= in_data;
                    default: ;
                endcase
            end
            if (state == WRITE && !last_word)
                addr <= addr + 1'b1;
        end
    end

    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            CNT_HI, CNT_LO, DATA_HI, DATA_LO: in_ready = 1'b1;
            WRITE: mem_we = 1'b1;
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERR: err = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr  = addr;
    assign mem_wdata = word;

endmodule

// File: tb/tb_subleq_loader.sv
// Scoreboard bench for subleq_loader: expected writes are queued as bytes are
// driven and retired by a monitor that watches mem_we.
module tb_subleq_loader;

    logic        clk = 1'b0;
    logic        areset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    subleq_loader #(
        .WORD_SIZE (16),
        .ADDR_WIDTH(16),
        .MEM_WORDS (256)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    int          acc_cyc;
    int          done_cyc = 0;
    logic        prev_done = 1'b0;
    logic [31:0] exp_q[$];
    logic [15:0] tb_mem[0:255];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr[7:0]] = mem_wdata;
            check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0)
                check("wr_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
        if (done && !prev_done) done_cyc = cyc;
        prev_done = done;
    end

    // Present a byte; returns at the negedge following the accepting edge
    // with in_valid still high.
    task automatic send_byte(input logic [7:0] b);
        logic ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[15:8]);
        if (gap > 0) begin in_valid = 1'b0; repeat (gap) @(negedge clk); end
        send_byte(w[7:0]);
        if (gap > 0) begin in_valid = 1'b0; repeat (gap) @(negedge clk); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset   = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        in_valid = 1'b0;
        while (!done && i < 50) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    task automatic stream_three(input int gap);
        int start;
        exp_q.push_back({16'd0, 16'h1234});
        exp_q.push_back({16'd1, 16'hABCD});
        exp_q.push_back({16'd2, 16'h0000});
        send_word(16'h0003, gap);
        start = acc_cyc - ((gap > 0) ? 0 : 1);
        send_word(16'h1234, gap);
        send_word(16'hABCD, gap);
        send_word(16'h0000, gap);
        wait_done("three_done");
        if (gap == 0) check("three_latency", 32'(done_cyc - start), 32'd11);
        check("three_q_empty", 32'(exp_q.size()), 32'd0);
        check("three_hold", 32'(cpu_hold), 32'd0);
        check("three_ready", 32'(in_ready), 32'd0);
        check("three_err", 32'(err), 32'd0);
        check("three_mem1", 32'(tb_mem[1]), 32'h0000ABCD);
    endtask

    initial begin
        logic saw_ready;
        int   start0;
        areset   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < 256; i++) tb_mem[i] = 16'hDEAD;

        // Reset values
        do_reset();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Back-to-back stream, 3 words
        send_byte(8'h00);
        start0 = acc_cyc;
        exp_q.push_back({16'd0, 16'h1234});
        exp_q.push_back({16'd1, 16'hABCD});
        exp_q.push_back({16'd2, 16'h0000});
        send_byte(8'h03);
        send_word(16'h1234, 0);
        send_word(16'hABCD, 0);
        send_word(16'h0000, 0);
        wait_done("b2b_done");
        check("b2b_latency", 32'(done_cyc - start0), 32'd11);
        check("b2b_q_empty", 32'(exp_q.size()), 32'd0);
        check("b2b_hold", 32'(cpu_hold), 32'd0);
        check("b2b_ready", 32'(in_ready), 32'd0);

        // Zero-length header
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        in_valid = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_hold", 32'(cpu_hold), 32'd0);
        check("zero_ready", 32'(in_ready), 32'd0);

        // Count 257 exceeds MEM_WORDS
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        check("err_flag", 32'(err), 32'd1);
        check("err_hold", 32'(cpu_hold), 32'd1);
        check("err_done", 32'(done), 32'd0);
        saw_ready = 1'b0;
        in_data   = 8'h55;
        repeat (4) begin
            saw_ready = saw_ready | in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("err_no_ready", 32'(saw_ready), 32'd0);
        check("err_sticky", 32'(err), 32'd1);

        // Stalled stream: 5 idle cycles between bytes
        do_reset();
        stream_three(5);

        // Count exactly MEM_WORDS is legal and fills the whole memory
        do_reset();
        send_word(16'h0100, 0);
        for (int i = 0; i < 256; i++) begin
            logic [15:0] w;
            w = 16'(i) * 16'h0101 ^ 16'h5A3C;
            exp_q.push_back({16'(i), w});
            send_word(w, 0);
        end
        wait_done("full_done");
        check("full_q_empty", 32'(exp_q.size()), 32'd0);
        check("full_mem255", 32'(tb_mem[255]), 32'(16'd255 * 16'h0101 ^ 16'h5A3C));
        check("full_err", 32'(err), 32'd0);

        // Reset while in DATA_LO of word 1
        do_reset();
        exp_q.push_back({16'd0, 16'h1122});
        send_word(16'h0002, 0);
        send_word(16'h1122, 0);
        send_byte(8'h33);
        in_data = 8'h44;
        areset  = 1'b1;
        @(negedge clk);
        areset   = 1'b0;
        in_valid = 1'b0;
        check("mid_q_empty", 32'(exp_q.size()), 32'd0);
        check("mid_mem0", 32'(tb_mem[0]), 32'h00001122);
        check("mid_ready", 32'(in_ready), 32'd1);
        check("mid_hold", 32'(cpu_hold), 32'd1);
        check("mid_done", 32'(done), 32'd0);
        exp_q.push_back({16'd0, 16'hBEEF});
        send_word(16'h0001, 0);
        send_word(16'hBEEF, 0);
        wait_done("mid_reload_done");
        check("mid_reload_q", 32'(exp_q.size()), 32'd0);
        check("mid_reload_mem0", 32'(tb_mem[0]), 32'h0000BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
